// File: rtl/pwm_cfg_spi_ctrl_if.sv
// ---------------------------------------------------------------------------
// pwm_cfg_spi_ctrl_if
// Purpose : bundles the SPI pins between an SPI controller (master) and the
//           pwm_cfg_spi_ctrl register block (slave).
// Signals : sclk    - SPI clock, mode 0, asynchronous to the system clock
//           ncs     - chip select, active low
//           copi    - controller-out / peripheral-in data, MSB first
//           cipo    - peripheral-out data (readback builds only)
//           cipo_oe - output enable for cipo
// ---------------------------------------------------------------------------
interface pwm_cfg_spi_ctrl_if;
  logic sclk;
  logic ncs;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (
    output sclk,
    output ncs,
    output copi,
    input  cipo,
    input  cipo_oe
  );

  modport slave (
    input  sclk,
    input  ncs,
    input  copi,
    output cipo,
    output cipo_oe
  );
endinterface

// File: rtl/pwm_cfg_spi_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_cfg_spi_ctrl
// Purpose : SPI write-only register block that configures the PWM/output
//           datapath. 16-bit frames (1 R/W, 7 address, 8 data, MSB first)
//           are received in the clk domain and committed into five 8-bit
//           configuration registers when ncs rises.
// Optional: define SPI_READBACK_EN to let read frames (bit15=0) return the
//           addressed register on cipo during bits 9-16.
// Ports   : clk          - system clock
//           rst_n        - asynchronous active-low reset
//           spi          - SPI pins (slave modport of pwm_cfg_spi_ctrl_if)
//           en_out_7_0   - register 0x00
//           en_out_15_8  - register 0x01
//           en_pwm_7_0   - register 0x02
//           en_pwm_15_8  - register 0x03
//           pwm_duty     - register 0x04
//           frame_err    - one-clk pulse when a frame is discarded
// Notes   : sclk high/low phases must each last at least 4 clk periods.
//           Only addresses 0..4 hold storage; MAX_ADDR is expected to be 4.
// ---------------------------------------------------------------------------
module pwm_cfg_spi_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4,
  parameter int FRAME_BITS  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  pwm_cfg_spi_ctrl_if.slave         spi,
  output logic [7:0]                en_out_7_0,
  output logic [7:0]                en_out_15_8,
  output logic [7:0]                en_pwm_7_0,
  output logic [7:0]                en_pwm_15_8,
  output logic [7:0]                pwm_duty,
  output logic                      frame_err
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] FRAME_CNT  = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(FRAME_BITS + 1);
  localparam logic [6:0]       MAX_ADDR_L = 7'(MAX_ADDR);

  localparam logic [1:0] WAIT_IDLE = 2'd0;
  localparam logic [1:0] IDLE      = 2'd1;
  localparam logic [1:0] SHIFT     = 2'd2;
  localparam logic [1:0] COMMIT    = 2'd3;

  logic [SYNC_STAGES-1:0] sclk_sync, ncs_sync, copi_sync;
  logic                   sclk_d, ncs_d;
  logic                   sclk_s, ncs_s, copi_s;
  logic                   sclk_rise, ncs_rise, ncs_fall;

  logic [1:0]             state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [FRAME_BITS-1:0]  shift_reg;

  logic [6:0]             frame_addr;
  logic                   frame_rw;
  logic                   len_ok, addr_ok, do_write;

  // Synchronizers reset to 0 so that a high ncs only appears as a level,
  // never as a falling edge, once reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      ncs_sync  <= '0;
      copi_sync <= '0;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi.ncs};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi.copi};
      sclk_d    <= sclk_s;
      ncs_d     <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign ncs_fall  = ~ncs_s & ncs_d;

  assign frame_rw   = shift_reg[FRAME_BITS-1];
  assign frame_addr = shift_reg[FRAME_BITS-2 -: 7];
  assign len_ok     = (bit_cnt == FRAME_CNT);
  assign addr_ok    = (frame_addr <= MAX_ADDR_L);
  assign do_write   = (state == COMMIT) && len_ok && addr_ok && frame_rw;
  assign frame_err  = (state == COMMIT) && (!len_ok || !addr_ok);

  // Frame FSM and register file. A frame only starts from IDLE, and IDLE is
  // only reached after ncs has been seen high, so a frame already running at
  // reset release is ignored. A falling ncs in COMMIT starts the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      en_out_7_0  <= 8'h00;
      en_out_15_8 <= 8'h00;
      en_pwm_7_0  <= 8'h00;
      en_pwm_15_8 <= 8'h00;
      pwm_duty    <= 8'h00;
    end else begin
      case (state)
        WAIT_IDLE: begin
          if (ncs_s) state <= IDLE;
        end
        IDLE: begin
          if (ncs_fall) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (ncs_rise) begin
            state <= COMMIT;
          end else if (sclk_rise && !ncs_s) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], copi_s};
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
          end
        end
        COMMIT: begin
          if (do_write) begin
            case (frame_addr)
              7'd0:    en_out_7_0  <= shift_reg[7:0];
              7'd1:    en_out_15_8 <= shift_reg[7:0];
              7'd2:    en_pwm_7_0  <= shift_reg[7:0];
              7'd3:    en_pwm_15_8 <= shift_reg[7:0];
              7'd4:    pwm_duty    <= shift_reg[7:0];
              default: ;
            endcase
          end
          if (ncs_fall) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            state     <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  localparam logic [CNT_W-1:0] LOAD_CNT  = CNT_W'(7);
  localparam logic [CNT_W-1:0] SHIFT_CNT = CNT_W'(9);

  logic       sclk_fall;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] out_shift;

  assign sclk_fall = ~sclk_s & sclk_d;
  // Address as it will stand once the 8th bit is shifted in this cycle.
  assign rd_addr   = {shift_reg[5:0], copi_s};

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      7'd0:    rd_data = en_out_7_0;
      7'd1:    rd_data = en_out_15_8;
      7'd2:    rd_data = en_pwm_7_0;
      7'd3:    rd_data = en_pwm_15_8;
      7'd4:    rd_data = pwm_duty;
      default: rd_data = 8'h00;
    endcase
  end

  // Output shifter: loaded on the 8th rising sclk, advanced on each falling
  // sclk once bit 9 has been sampled by the controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_shift <= 8'h00;
    end else if ((state == IDLE || state == COMMIT) && ncs_fall) begin
      out_shift <= 8'h00;
    end else if (state == SHIFT && !ncs_rise && !ncs_s && sclk_rise &&
                 bit_cnt == LOAD_CNT) begin
      out_shift <= rd_data;
    end else if (state == SHIFT && !ncs_s && sclk_fall && bit_cnt >= SHIFT_CNT) begin
      out_shift <= {out_shift[6:0], 1'b0};
    end
  end

  assign spi.cipo    = out_shift[7];
  assign spi.cipo_oe = (state == SHIFT) && !ncs_s;
`else
  assign spi.cipo    = 1'b0;
  assign spi.cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_cfg_spi_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pwm_cfg_spi_ctrl
// Self-checking bench for pwm_cfg_spi_ctrl: hand sequences for reset,
// latency, back-to-back and mid-frame reset, a table of directed frames and
// a randomized run against a register-map model.
// ---------------------------------------------------------------------------
module tb_pwm_cfg_spi_ctrl;

  localparam int HALF = 5;

`ifdef SPI_READBACK_EN
  localparam logic EXP_OE = 1'b1;
  localparam logic READBACK = 1'b1;
`else
  localparam logic EXP_OE = 1'b0;
  localparam logic READBACK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] en_out_7_0, en_out_15_8, en_pwm_7_0, en_pwm_15_8, pwm_duty;
  logic       frame_err;

  pwm_cfg_spi_ctrl_if spi_bus ();

  pwm_cfg_spi_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi         (spi_bus),
    .en_out_7_0  (en_out_7_0),
    .en_out_15_8 (en_out_15_8),
    .en_pwm_7_0  (en_pwm_7_0),
    .en_pwm_15_8 (en_pwm_15_8),
    .pwm_duty    (pwm_duty),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_miss = 0;
  int         err_pulses = 0;
  logic [7:0] rx_byte;
  logic       oe_mid;

  // Count frame_err pulses on the falling edge, where COMMIT is stable.
  always @(negedge clk) begin
    if (frame_err === 1'b1) err_pulses <= err_pulses + 1;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [16:0] bits;
    int          nbits;
    logic [39:0] exp_regs;
    int          exp_err;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [39:0] getRegs();
    return {pwm_duty, en_pwm_15_8, en_pwm_7_0, en_out_15_8, en_out_7_0};
  endfunction

  function automatic logic [7:0] getReg(input int idx);
    logic [39:0] r;
    r = getRegs();
    return r[8*idx +: 8];
  endfunction

  task automatic checkOutput(input string name, input logic [39:0] actual,
                             input logic [39:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clock out nbits of 'bits' MSB first with ncs already low; captures cipo
  // during bits 9-16 and the cipo_oe level mid-frame.
  task automatic spiBits(input logic [16:0] bits, input int nbits);
    rx_byte = 8'h00;
    oe_mid  = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      spi_bus.copi = bits[nbits-1-i];
      waitClk(HALF);
      if (i >= 8 && i < 16) rx_byte = {rx_byte[6:0], spi_bus.cipo};
      if (i == 4) oe_mid = spi_bus.cipo_oe;
      spi_bus.sclk = 1'b1;
      waitClk(HALF);
      spi_bus.sclk = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [16:0] bits, input int nbits);
    spi_bus.ncs = 1'b0;
    waitClk(HALF);
    spiBits(bits, nbits);
    waitClk(HALF);
    spi_bus.ncs = 1'b1;
    waitClk(8);
  endtask

  // Counts rising clk edges after the ncs rise until the register shows exp.
  task automatic measureLatency(input int idx, input logic [7:0] exp);
    int e;
    e = 9;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (getReg(idx) == exp) begin
        e = k;
        break;
      end
    end
    checkOutput($sformatf("latency_reg%0d", idx), 40'(e), 40'(4));
  endtask

  initial begin
    logic [7:0]  model [5];
    logic [16:0] b2b [4];
    logic [7:0]  b2b_dat [4];
    int          err0;

    vecs[0] = '{17'h080F0, 16, 40'h00_00_00_00_F0, 0};
    vecs[1] = '{17'h085FF, 16, 40'h00_00_00_00_F0, 1};
    vecs[2] = '{17'h04209, 15, 40'h00_00_00_00_F0, 1};
    vecs[3] = '{17'h10824, 17, 40'h00_00_00_00_F0, 1};
    vecs[4] = '{17'h00099, 16, 40'h00_00_00_00_F0, 0};
    vecs[5] = '{17'h08107, 16, 40'h00_00_00_07_F0, 0};
    vecs[6] = '{17'h08F01, 16, 40'h00_00_00_07_F0, 1};

    rst_n        = 1'b0;
    spi_bus.ncs  = 1'b0;
    spi_bus.sclk = 1'b0;
    spi_bus.copi = 1'b0;
    waitClk(4);
    checkOutput("reset_regs", getRegs(), 40'h0);
    checkOutput("reset_pins", 40'({spi_bus.cipo, spi_bus.cipo_oe, frame_err}), 40'h0);

    // Release reset with ncs already low: the frame must be ignored.
    rst_n = 1'b1;
    waitClk(3);
    err0 = err_pulses;
    spiBits(17'h080F0, 16);
    waitClk(HALF);
    spi_bus.ncs = 1'b1;
    waitClk(8);
    checkOutput("no_start_regs", getRegs(), 40'h0);
    checkOutput("no_start_err", 40'(err_pulses - err0), 40'h0);

    // Directed table.
    foreach (vecs[i]) begin
      err0 = err_pulses;
      applyStimulus(vecs[i].bits, vecs[i].nbits);
      checkOutput($sformatf("vec%0d_regs", i), getRegs(), vecs[i].exp_regs);
      checkOutput($sformatf("vec%0d_err", i), 40'(err_pulses - err0), 40'(vecs[i].exp_err));
      checkOutput($sformatf("vec%0d_oe", i), 40'({oe_mid, spi_bus.cipo_oe}), 40'({EXP_OE, 1'b0}));
      if (!READBACK) checkOutput($sformatf("vec%0d_cipo", i), 40'(rx_byte), 40'h0);
    end

    // Back-to-back writes with a single clk of ncs high between frames.
    b2b[0] = 17'h08155; b2b_dat[0] = 8'h55;
    b2b[1] = 17'h082AA; b2b_dat[1] = 8'hAA;
    b2b[2] = 17'h08333; b2b_dat[2] = 8'h33;
    b2b[3] = 17'h08480; b2b_dat[3] = 8'h80;
    spi_bus.ncs = 1'b0;
    waitClk(HALF);
    spiBits(b2b[0], 16);
    for (int k = 0; k < 4; k++) begin
      waitClk(HALF);
      spi_bus.ncs = 1'b1;
      fork
        measureLatency(k + 1, b2b_dat[k]);
        begin
          if (k < 3) begin
            waitClk(1);
            spi_bus.ncs = 1'b0;
            waitClk(HALF);
            spiBits(b2b[k+1], 16);
          end
        end
      join
    end
    waitClk(8);
    checkOutput("b2b_regs", getRegs(), 40'h80_33_AA_55_F0);

    // Read of pwm_duty.
    err0 = err_pulses;
    applyStimulus(17'h00400, 16);
    checkOutput("read_data", 40'(rx_byte), READBACK ? 40'h80 : 40'h0);
    checkOutput("read_oe", 40'({oe_mid, spi_bus.cipo_oe}), 40'({EXP_OE, 1'b0}));
    checkOutput("read_regs", getRegs(), 40'h80_33_AA_55_F0);
    checkOutput("read_err", 40'(err_pulses - err0), 40'h0);

    // Randomized frames against the register-map model.
    model[0] = 8'hF0; model[1] = 8'h55; model[2] = 8'hAA;
    model[3] = 8'h33; model[4] = 8'h80;
    for (int n = 0; n < 40; n++) begin
      logic        rw;
      logic [6:0]  addr;
      logic [7:0]  data;
      logic [15:0] f;
      logic [16:0] bits;
      logic [7:0]  exp_rx;
      int          nb, sel, exp_err;
      rw   = ($urandom_range(0, 3) != 0);
      addr = 7'($urandom_range(0, 6));
      data = 8'($urandom);
      f    = {rw, addr, data};
      sel  = $urandom_range(0, 9);
      if (sel == 0) begin
        nb = 15; bits = {2'b00, f[15:1]};
      end else if (sel == 1) begin
        nb = 17; bits = {f, 1'b1};
      end else begin
        nb = 16; bits = {1'b0, f};
      end
      exp_rx = (addr <= 7'd4) ? model[addr] : 8'h00;
      exp_err = (nb != 16 || addr > 7'd4) ? 1 : 0;
      if (nb == 16 && rw && addr <= 7'd4) model[addr] = data;
      err0 = err_pulses;
      applyStimulus(bits, nb);
      checkOutput($sformatf("rand%0d_regs", n), getRegs(),
                  {model[4], model[3], model[2], model[1], model[0]});
      checkOutput($sformatf("rand%0d_err", n), 40'(err_pulses - err0), 40'(exp_err));
      if (!READBACK)
        checkOutput($sformatf("rand%0d_cipo", n), 40'(rx_byte), 40'h0);
      else if (nb == 16 && !rw)
        checkOutput($sformatf("rand%0d_rdata", n), 40'(rx_byte), 40'(exp_rx));
    end

    // Reset in the middle of a write frame.
    err0 = err_pulses;
    spi_bus.ncs = 1'b0;
    waitClk(HALF);
    spiBits(17'h00082, 8);
    waitClk(2);
    rst_n = 1'b0;
    waitClk(2);
    checkOutput("midreset_regs", getRegs(), 40'h0);
    rst_n = 1'b1;
    waitClk(2);
    spiBits(17'h00077, 8);
    waitClk(HALF);
    spi_bus.ncs = 1'b1;
    waitClk(8);
    checkOutput("midreset_after_regs", getRegs(), 40'h0);
    checkOutput("midreset_err", 40'(err_pulses - err0), 40'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
